// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the register file scoreboard.
// Register 0 is hardwired to zero; LINK_REG is the JAL destination (no special handling).
package rf_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;
  localparam int NREGS    = 2 ** ADDR_W;
  localparam int REG_ZERO = 0;
  localparam int LINK_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  reg_cnt_t;

  localparam reg_cnt_t CNT_MAX = '1;
  localparam reg_cnt_t CNT_ONE = reg_cnt_t'(1);
endpackage

// File: rtl/regfile_scoreboard_busy_counter.sv
// Per-register pending-write counter: issue increments, retire decrements.
// A retire against an empty counter leaves it at zero and flags underflow.
module reg_busy_counter
  import rf_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     inc,
  input  logic     dec,
  output reg_cnt_t cnt,
  output logic     busy,
  output logic     full,
  output logic     underflow
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNT_ONE;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // no clamp on inc: the issuer's stall term keeps a full counter from being incremented
  assign busy      = (cnt != '0);
  assign full      = (cnt == CNT_MAX);
  assign underflow = dec && (cnt == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard between decode and writeback.
// Optional macro WB_BYPASS_EN forwards the retiring value to reads and clears the last pending write early.
module regfile_scoreboard
  import rf_pkg::*;
(
  input  logic      Clk,
  input  logic      Reset,
  input  logic      IssueValid,
  input  logic      IssueRegWrite,
  input  reg_addr_t IssueDst,
  input  reg_addr_t RsAddr,
  input  reg_addr_t RtAddr,
  output reg_data_t RsData,
  output reg_data_t RtData,
  output logic      Stall,
  input  logic      WbValid,
  input  logic      WbRegWrite,
  input  reg_addr_t WbDst,
  input  reg_data_t WbData,
  output logic      ErrUnderflow
);

  reg_data_t        regs [NREGS];
  reg_cnt_t         cnt_v [NREGS];
  logic [NREGS-1:0] inc_v;
  logic [NREGS-1:0] dec_v;
  logic [NREGS-1:0] busy_v;
  logic [NREGS-1:0] full_v;
  logic [NREGS-1:0] uf_v;

  logic retire;
  logic issue_wr;
  logic rs_busy;
  logic rt_busy;

  assign retire   = WbValid && WbRegWrite && (WbDst != reg_addr_t'(REG_ZERO));
  assign issue_wr = IssueValid && !Stall && IssueRegWrite && (IssueDst != reg_addr_t'(REG_ZERO));

  // register 0 has no counter: never busy, never full
  assign inc_v[0]  = 1'b0;
  assign dec_v[0]  = 1'b0;
  assign busy_v[0] = 1'b0;
  assign full_v[0] = 1'b0;
  assign uf_v[0]   = 1'b0;
  assign cnt_v[0]  = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_cnt
    assign inc_v[g] = issue_wr && (IssueDst == reg_addr_t'(g));
    assign dec_v[g] = retire && (WbDst == reg_addr_t'(g));

    reg_busy_counter u_cnt (
      .clk       (Clk),
      .rst_n     (Reset),
      .inc       (inc_v[g]),
      .dec       (dec_v[g]),
      .cnt       (cnt_v[g]),
      .busy      (busy_v[g]),
      .full      (full_v[g]),
      .underflow (uf_v[g])
    );
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (retire) begin
      regs[WbDst] <= WbData;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ErrUnderflow <= 1'b0;
    end else if (|uf_v) begin
      ErrUnderflow <= 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // a register whose last pending write lands this cycle is already readable via the bypass
  always_comb begin
    rs_busy = busy_v[RsAddr];
    rt_busy = busy_v[RtAddr];
    if (retire && (WbDst == RsAddr) && (cnt_v[RsAddr] == CNT_ONE)) rs_busy = 1'b0;
    if (retire && (WbDst == RtAddr) && (cnt_v[RtAddr] == CNT_ONE)) rt_busy = 1'b0;
  end

  always_comb begin
    RsData = (RsAddr == reg_addr_t'(REG_ZERO)) ? '0 : regs[RsAddr];
    RtData = (RtAddr == reg_addr_t'(REG_ZERO)) ? '0 : regs[RtAddr];
    if (retire && (WbDst == RsAddr)) RsData = WbData;
    if (retire && (WbDst == RtAddr)) RtData = WbData;
  end
`else
  always_comb begin
    rs_busy = busy_v[RsAddr];
    rt_busy = busy_v[RtAddr];
  end

  always_comb begin
    RsData = (RsAddr == reg_addr_t'(REG_ZERO)) ? '0 : regs[RsAddr];
    RtData = (RtAddr == reg_addr_t'(REG_ZERO)) ? '0 : regs[RtAddr];
  end
`endif

  assign Stall = IssueValid && (rs_busy || rt_busy ||
                 (IssueRegWrite && (IssueDst != reg_addr_t'(REG_ZERO)) && full_v[IssueDst]));

endmodule
